// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// address geometry, controller states and address slicing helpers.
package dcache_pkg;

    localparam int ADDR_W  = 15;
    localparam int INDEX_W = 12;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_FETCH     = 3'd2,
        ST_FILL      = 3'd3,
        ST_WRITE_MEM = 3'd4
    } state_t;

    // Upper address bits identify which memory block occupies a line
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    // Lower address bits select the cache line
    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count events, holding at the maximum value instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dcache_ctrl.sv
// Sequencing controller for a 4K-line direct-mapped data cache.
// Reads that miss are fetched from main memory and filled into the line;
// writes go to the cache line (allocating over any conflicting line) and
// always through to main memory, so memory never holds stale data and no
// writeback path is needed. Hit/miss statistics saturate.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    // CPU memory stage
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [14:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    // Cache array
    output logic [14:0]       cache_addr,
    output logic              cache_write,
    output logic [31:0]       cache_wdata,
    input  logic              cache_valid,
    input  logic [2:0]        cache_tag,
    input  logic [31:0]       cache_rdata,
    // Main memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [14:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    // Statistics
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int CNT_HIT  = 0;
    localparam int CNT_MISS = 1;
    localparam int N_CNT    = 2;

    state_t              state_reg;
    state_t              state_next;

    // Request captured in IDLE; the CPU may change its inputs afterwards
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    // Word returned by memory on a read miss, replayed to cache and CPU
    logic [DATA_W-1:0]   fill_reg;

    logic                hit;
    logic [N_CNT-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_val [N_CNT];

    // Line matches when it is valid and holds the requested block
    assign hit = cache_valid && (cache_tag == addr_tag(addr_reg));

    // The cache array is always indexed by the latched request
    assign cache_addr = addr_reg;

    // State register plus request and fill capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && cpu_req) begin
                we_reg    <= cpu_we;
                addr_reg  <= cpu_addr;
                wdata_reg <= cpu_wdata;
            end
            if ((state_reg == ST_FETCH) && mem_ack) begin
                fill_reg <= mem_rdata;
            end
        end
    end

    // Next-state and output decode from the registered state
    always_comb begin
        state_next  = state_reg;
        cpu_busy    = (state_reg != ST_IDLE);
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        cache_write = 1'b0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        cnt_inc     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_next = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (we_reg) begin
                    // Write-allocate: overwrite the line regardless of hit,
                    // memory is updated next so nothing is lost
                    cache_write = 1'b1;
                    cache_wdata = wdata_reg;
                    if (hit) begin
                        cnt_inc[CNT_HIT] = 1'b1;
                    end else begin
                        cnt_inc[CNT_MISS] = 1'b1;
                    end
                    state_next = ST_WRITE_MEM;
                end else if (hit) begin
                    cpu_ready        = 1'b1;
                    cpu_rdata        = cache_rdata;
                    cnt_inc[CNT_HIT] = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    cnt_inc[CNT_MISS] = 1'b1;
                    state_next        = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = addr_reg;
                if (mem_ack) begin
                    state_next = ST_FILL;
                end
            end

            ST_FILL: begin
                // Fill the line and answer the CPU in the same cycle
                cache_write = 1'b1;
                cache_wdata = fill_reg;
                cpu_ready   = 1'b1;
                cpu_rdata   = fill_reg;
                state_next  = ST_IDLE;
            end

            ST_WRITE_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_reg;
                mem_wdata = wdata_reg;
                if (mem_ack) begin
                    cpu_ready  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One saturating counter per statistic (hit, miss)
    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign hit_count  = cnt_val[CNT_HIT];
    assign miss_count = cnt_val[CNT_MISS];

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: cache array and main memory are modelled around
// the DUT; every transaction is checked against a reference model that tracks
// which block each line holds and what memory contains.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy, cpu_ready;
    logic [31:0] cpu_rdata;
    logic [14:0] cache_addr;
    logic        cache_write;
    logic [31:0] cache_wdata;
    logic        cache_valid;
    logic [2:0]  cache_tag;
    logic [31:0] cache_rdata;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    // Second instance with tiny counters, fed by a line that always hits
    logic        cpu_req2;
    logic        cpu_busy2, cpu_ready2;
    logic [31:0] cpu_rdata2;
    logic [14:0] cache_addr2;
    logic        cache_write2;
    logic [31:0] cache_wdata2;
    logic        mem_req2, mem_we2;
    logic [14:0] mem_addr2;
    logic [31:0] mem_wdata2;
    logic [1:0]  hit_count2, miss_count2;

    int num_checks = 0;
    int num_errors = 0;

    dcache_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cache_addr(cache_addr), .cache_write(cache_write), .cache_wdata(cache_wdata),
        .cache_valid(cache_valid), .cache_tag(cache_tag), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req2), .cpu_we(1'b0), .cpu_addr(15'h0123), .cpu_wdata(32'h0),
        .cpu_busy(cpu_busy2), .cpu_ready(cpu_ready2), .cpu_rdata(cpu_rdata2),
        .cache_addr(cache_addr2), .cache_write(cache_write2), .cache_wdata(cache_wdata2),
        .cache_valid(1'b1), .cache_tag(3'd0), .cache_rdata(32'hA5A50000),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ack(1'b0), .mem_rdata(32'h0),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    // Initial memory contents (location 5 holds a recognisable word)
    function automatic logic [31:0] init_val(input logic [14:0] a);
        if (a == 15'h0005) return 32'hDEADBEEF;
        return ({17'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // ---------------- cache array environment ----------------
    logic        c_valid [4096];
    logic [2:0]  c_tag   [4096];
    logic [31:0] c_data  [4096];

    assign cache_valid = c_valid[cache_addr[11:0]];
    assign cache_tag   = c_tag[cache_addr[11:0]];
    assign cache_rdata = c_data[cache_addr[11:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) c_valid[i] <= 1'b0;
        end else if (cache_write) begin
            c_valid[cache_addr[11:0]] <= 1'b1;
            c_tag[cache_addr[11:0]]   <= cache_addr[14:12];
            c_data[cache_addr[11:0]]  <= cache_wdata;
        end
    end

    // ---------------- main memory environment ----------------
    logic [31:0] mem_arr     [32768];
    bit          mem_written [32768];
    int          mem_lat = 0;
    bit          late_ack_win = 1'b0;
    int          wait_cnt = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (rst) begin
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt >= mem_lat) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_arr[mem_addr]     = mem_wdata;
                    mem_written[mem_addr] = 1'b1;
                end else begin
                    mem_rdata = mem_written[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (late_ack_win) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit          ref_valid [4096];
    logic [2:0]  ref_tag   [4096];
    logic [31:0] ref_mem   [int];
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] ref_read(input logic [14:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        assert (obs === exp) else begin
            num_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU transaction, started and finished at a falling edge in IDLE
    task automatic txn(input logic we, input logic [14:0] a, input logic [31:0] wd, input int lat);
        logic        exp_hit;
        logic [31:0] exp_data;
        logic [11:0] idx;
        int          ready_cyc, mreq_cyc, cw_cnt, cw_cyc;
        int          exp_ready, exp_mreq, exp_cw_cnt, exp_cw_cyc;
        logic [31:0] got_rdata, cw_data;
        logic [14:0] cw_addr;
        logic        mbus_ok;

        idx       = a[11:0];
        exp_hit   = ref_valid[idx] && (ref_tag[idx] == a[14:12]);
        exp_data  = we ? wd : ref_read(a);
        ready_cyc = 0; mreq_cyc = 0; cw_cnt = 0; cw_cyc = 0;
        got_rdata = '0; cw_data = '0; cw_addr = '0; mbus_ok = 1'b1;

        mem_lat   = lat;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the CPU inputs: the controller must work from its latch
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = 15'($urandom);
        cpu_wdata = $urandom;
        check("busy_in_compare", cpu_busy, 1'b1);

        for (int c = 1; c <= 60 && ready_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_req) begin
                mreq_cyc++;
                if (mem_addr !== a || mem_we !== we || (we && mem_wdata !== wd)) mbus_ok = 1'b0;
            end
            if (cache_write) begin
                cw_cnt++;
                cw_cyc  = c;
                cw_data = cache_wdata;
                cw_addr = cache_addr;
            end
            if (cpu_ready) begin
                ready_cyc = c;
                got_rdata = cpu_rdata;
            end
        end

        if (we) begin
            exp_ready = 2 + lat; exp_mreq = lat + 1; exp_cw_cnt = 1; exp_cw_cyc = 1;
        end else if (exp_hit) begin
            exp_ready = 1; exp_mreq = 0; exp_cw_cnt = 0; exp_cw_cyc = 0;
        end else begin
            exp_ready = 3 + lat; exp_mreq = lat + 1; exp_cw_cnt = 1; exp_cw_cyc = 3 + lat;
        end

        // Reference update: line now holds this block, memory holds writes
        if (we || !exp_hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[14:12];
        end
        if (we) ref_mem[int'(a)] = wd;
        if (exp_hit) begin
            if (exp_hits < 65535) exp_hits++;
        end else begin
            if (exp_misses < 65535) exp_misses++;
        end

        check("ready_cycle", 32'(ready_cyc), 32'(exp_ready));
        check("mem_req_cycles", 32'(mreq_cyc), 32'(exp_mreq));
        check("mem_bus", mbus_ok, 1'b1);
        check("cache_write_count", 32'(cw_cnt), 32'(exp_cw_cnt));
        if (exp_cw_cnt != 0) begin
            check("cache_write_cycle", 32'(cw_cyc), 32'(exp_cw_cyc));
            check("cache_wdata", cw_data, exp_data);
            check("cache_addr", {17'h0, cw_addr}, {17'h0, a});
        end
        if (!we) check("cpu_rdata", got_rdata, exp_data);

        @(negedge clk);
        check("idle_after_ready", {cpu_busy, cpu_ready}, 2'b00);
        check("hit_count", {16'h0, hit_count}, 32'(exp_hits));
        check("miss_count", {16'h0, miss_count}, 32'(exp_misses));
        $display("txn %s addr=0x%04h wdata=0x%08h lat=%0d expect_%s ready_cyc=%0d rdata=0x%08h hits=%0d misses=%0d",
                 we ? "WR" : "RD", a, wd, lat, exp_hit ? "hit" : "miss", ready_cyc, got_rdata,
                 hit_count, miss_count);
    endtask

    // Safety net against a hung DUT
    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] ra;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_req2 = 1'b0;
        for (int i = 0; i < 4096; i++) ref_valid[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ctrl", {cpu_busy, cpu_ready, cache_write, mem_req, mem_we}, 5'b0);
        check("rst_cache_addr", {17'h0, cache_addr}, 32'h0);
        check("rst_mem_addr", {17'h0, mem_addr}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_cache_wdata", cache_wdata, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_counts", {hit_count, miss_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: miss, hit, conflict replacement, write-allocate
        txn(1'b0, 15'h0005, 32'h0, 3);
        txn(1'b0, 15'h0005, 32'h0, 0);
        txn(1'b0, 15'h1005, 32'h0, 1);
        txn(1'b0, 15'h0005, 32'h0, 0);
        txn(1'b1, 15'h2ABC, 32'h12345678, 2);
        txn(1'b0, 15'h2ABC, 32'h0, 0);
        txn(1'b1, 15'h3ABC, 32'hCAFEF00D, 0);
        txn(1'b0, 15'h2ABC, 32'h0, 2);

        // Random mix over a few lines and tags to get hits, misses, conflicts
        for (int n = 0; n < 40; n++) begin
            ra = {3'($urandom_range(0, 3)), 12'h0F0 + 12'($urandom_range(0, 5))};
            txn(($urandom_range(0, 2) == 0), ra, $urandom, $urandom_range(0, 3));
        end

        // Reset while a fetch is outstanding
        mem_lat  = 20;
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0777;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("fetch_mem_req", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_mem_req", mem_req, 1'b0);
        check("rst_mid_busy", cpu_busy, 1'b0);
        check("rst_mid_ready", cpu_ready, 1'b0);
        check("rst_mid_counts", {hit_count, miss_count}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4096; i++) ref_valid[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        late_ack_win = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_ack_ignored", {cpu_ready, cpu_busy, cache_write}, 3'b000);
        end
        late_ack_win = 1'b0;
        @(negedge clk);
        $display("reset during fetch: mem_req=%0b busy=%0b hits=%0d misses=%0d", mem_req, cpu_busy, hit_count, miss_count);
        txn(1'b0, 15'h0005, 32'h0, 1);

        // Counter saturation on the narrow-counter instance
        for (int i = 1; i <= 5; i++) begin
            cpu_req2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            cpu_req2 = 1'b0;
            check("sat_ready", cpu_ready2, 1'b1);
            check("sat_rdata", cpu_rdata2, 32'hA5A50000);
            @(negedge clk);
            check("sat_hit_count", {30'h0, hit_count2}, (i > 3) ? 32'd3 : 32'(i));
            $display("sat read %0d: hit_count=%0d miss_count=%0d", i, hit_count2, miss_count2);
        end
        check("sat_miss_count", {30'h0, miss_count2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Sequencing controller for the 4K-entry direct-mapped data cache (12-bit index, 3-bit tag, 15-bit word address into 32K-word main memory). It accepts single-word CPU read/write requests and checks the cache array. It services read misses by fetching from main memory and filling the line, and handles writes as write-through with write-allocate. It sits between the CPU memory stage, the cache array and the main-memory port, and keeps saturating hit/miss statistics.

## Interface
- CNT_W, 16, width of hit/miss statistic counters
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read, sampled with cpu_req
- cpu_addr  in  15  word address: [14:12] tag, [11:0] index
- cpu_wdata  in  32  write data
- cpu_busy  out  1  high in every state except IDLE
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid only while cpu_ready=1 on a read
- cache_addr  out  15  address to cache array (latched request address)
- cache_write  out  1  one-cycle write strobe to cache array
- cache_wdata  out  32  data to cache array
- cache_valid  in  1  valid bit of indexed line (combinational read)
- cache_tag  in  3  stored tag of indexed line (combinational read)
- cache_rdata  in  32  stored data of indexed line (combinational read)
- mem_req  out  1  main-memory request, held until mem_ack
- mem_we  out  1  main-memory write enable, held with mem_req
- mem_addr  out  15  main-memory address, held with mem_req
- mem_wdata  out  32  main-memory write data, held with mem_req
- mem_ack  in  1  one-cycle completion from memory; rdata valid same cycle
- mem_rdata  in  32  main-memory read data
- hit_count, miss_count  out  CNT_W  saturating statistics

## Operation
- States: IDLE, COMPARE, FETCH, FILL, WRITE_MEM.
- IDLE: when cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to COMPARE. Otherwise stay. cpu_req is ignored in all other states.
- COMPARE: hit = cache_valid && cache_tag == addr[14:12].
  - Read hit: cpu_ready=1, cpu_rdata=cache_rdata, increment hit_count, go to IDLE.
  - Read miss: increment miss_count, go to FETCH.
  - Write (hit or miss): cache_write=1 with cache_wdata=latched wdata, count a hit or a miss, go to WRITE_MEM. The write allocates and replaces any conflicting line without writeback; memory is always current.
- FETCH: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack, capture mem_rdata into the fill register and go to FILL.
- FILL: cache_write=1 with cache_wdata=fill register. In the same cycle, cpu_ready=1 and cpu_rdata=fill register. Go to IDLE.
- WRITE_MEM: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack, cpu_ready=1 in that same cycle, then go to IDLE.
- mem_ack outside FETCH and WRITE_MEM is ignored.
- Counters saturate at all-ones and never wrap.
- Reset values: state IDLE; cpu_busy, cpu_ready, cache_write, mem_req and mem_we all 0; all data, address and counter outputs 0.
- Reset mid-transaction: state goes to IDLE and mem_req drops in the cycle after the reset edge. The in-flight request is abandoned and no cpu_ready is issued. The memory side must tolerate a dropped request. Cache valid bits are cleared by the cache array's own reset, not by this block.

## Timing
- All outputs are registered-state decodes; none depends combinationally on cpu_req.
- Read hit: request accepted at edge N, cpu_ready high in cycle N+1.
- Read miss: cpu_ready in the cycle after the mem_ack edge (FILL). Total latency = 2 + memory latency.
- Write: cache updated at the end of the COMPARE cycle. cpu_ready coincides with mem_ack.
- Back-to-back: a new request may be sampled in the first IDLE cycle after cpu_ready.
- A mem_ack in the same cycle mem_req first rises is legal.

## Structure
- Shared package dcache_pkg holds:
  - constants ADDR_W=15, INDEX_W=12, TAG_W=3, DATA_W=32;
  - the state enum;
  - tag/index slice helpers.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), is instantiated twice.

## Test plan
- After reset, read 0x0005 with memory acking 0xDEADBEEF three cycles later -> one mem_req at 0x0005, cache_write at index 0x005 with tag 0, cpu_ready with 0xDEADBEEF, miss_count=1.
- Then read 0x0005 -> cpu_ready one cycle after accept, rdata 0xDEADBEEF, no mem_req, hit_count=1.
- Read 0x1005 (same index, tag 1) -> miss, fetch from 0x1005, line replaced. A following read of 0x0005 misses again.
- Write 0x2ABC with 0x12345678, ack after 2 cycles -> cache_write in COMPARE, mem_we held until ack, cpu_ready on ack. A following read of 0x2ABC hits with 0x12345678.
- Assert rst during FETCH -> next cycle mem_req=0, cpu_busy=0, counters 0, and no cpu_ready. A late mem_ack is ignored.
- With CNT_W=2, perform 5 read hits -> hit_count stays at 3.
